// File: rtl/bus_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bus_control_sequencer
// Purpose  : Timing/control sequencer for the basic computer. Steps the
//            sequence counter through fetch, decode, indirect and execute,
//            and decodes the one-hot bus source select plus register,
//            memory and ALU strobes.
// Revision : 1.0 - initial release
// ============================================================================
module bus_control_sequencer #(
   parameter int SC_W = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            run,
   input  logic [2:0]      ir_op,
   input  logic            ir_i,
   input  logic            dr_zero,
   output logic [6:0]      x_sel,
   output logic            ar_ld,
   output logic            ar_inc,
   output logic            pc_ld,
   output logic            pc_inc,
   output logic            dr_ld,
   output logic            dr_inc,
   output logic            ac_ld,
   output logic            ir_ld,
   output logic            tr_ld,
   output logic            mem_wr,
   output logic [1:0]      alu_sel,
   output logic            rr_exec,
   output logic            i_q,
   output logic [SC_W-1:0] t_cnt
);

   // Sequence counter values
   localparam logic [SC_W-1:0] c_T0 = SC_W'(0);
   localparam logic [SC_W-1:0] c_T1 = SC_W'(1);
   localparam logic [SC_W-1:0] c_T2 = SC_W'(2);
   localparam logic [SC_W-1:0] c_T3 = SC_W'(3);
   localparam logic [SC_W-1:0] c_T4 = SC_W'(4);
   localparam logic [SC_W-1:0] c_T5 = SC_W'(5);
   localparam logic [SC_W-1:0] c_T6 = SC_W'(6);

   // One-hot bus sources
   localparam logic [6:0] c_X_M  = 7'b1000000;
   localparam logic [6:0] c_X_IR = 7'b0010000;
   localparam logic [6:0] c_X_AC = 7'b0001000;
   localparam logic [6:0] c_X_DR = 7'b0000100;
   localparam logic [6:0] c_X_PC = 7'b0000010;
   localparam logic [6:0] c_X_AR = 7'b0000001;

   // Memory-reference opcodes; 7 is the register-reference/IO group
   localparam logic [2:0] c_OP_AND = 3'd0;
   localparam logic [2:0] c_OP_ADD = 3'd1;
   localparam logic [2:0] c_OP_LDA = 3'd2;
   localparam logic [2:0] c_OP_STA = 3'd3;
   localparam logic [2:0] c_OP_BUN = 3'd4;
   localparam logic [2:0] c_OP_BSA = 3'd5;
   localparam logic [2:0] c_OP_ISZ = 3'd6;
   localparam logic [2:0] c_OP_RR  = 3'd7;

   logic [SC_W-1:0] r_sc;
   logic [2:0]      r_op;
   logic            r_iq;
   logic            r_active;

   logic [SC_W-1:0] w_sc_nxt;
   logic            w_active_nxt;
   logic            w_latch;
   logic            w_clr;

   // Decode the current timing step into strobes and the next SC value
   always_comb begin
      x_sel        = 7'b0;
      ar_ld        = 1'b0;
      ar_inc       = 1'b0;
      pc_ld        = 1'b0;
      pc_inc       = 1'b0;
      dr_ld        = 1'b0;
      dr_inc       = 1'b0;
      ac_ld        = 1'b0;
      ir_ld        = 1'b0;
      mem_wr       = 1'b0;
      alu_sel      = 2'b00;
      rr_exec      = 1'b0;
      w_latch      = 1'b0;
      w_clr        = 1'b0;
      w_sc_nxt     = r_sc;
      w_active_nxt = r_active;

      // Reset is asynchronous; outputs are forced quiet while it is held so no
      // partial strobe escapes in the reset cycle.
      if (!rst) begin
         if (r_sc == c_T0) begin
            // run is only looked at here; a stalled T0 holds with all outputs 0
            if (run) begin
               x_sel        = c_X_PC;
               ar_ld        = 1'b1;
               w_sc_nxt     = c_T1;
               w_active_nxt = 1'b1;
            end
         end else if (!r_active) begin
            // Non-zero SC without an instruction in flight is unreachable
            w_clr = 1'b1;
         end else begin
            case (r_sc)
               c_T1: begin
                  x_sel    = c_X_M;
                  ir_ld    = 1'b1;
                  pc_inc   = 1'b1;
                  w_sc_nxt = c_T2;
               end
               c_T2: begin
                  x_sel    = c_X_IR;
                  ar_ld    = 1'b1;
                  w_latch  = 1'b1;
                  w_sc_nxt = c_T3;
               end
               c_T3: begin
                  if (r_op == c_OP_RR) begin
                     rr_exec = 1'b1;
                     w_clr   = 1'b1;
                  end else begin
                     // T3 is spent even for direct addressing, so indirect
                     // costs no extra cycles
                     if (r_iq) begin
                        x_sel = c_X_M;
                        ar_ld = 1'b1;
                     end
                     w_sc_nxt = c_T4;
                  end
               end
               c_T4: begin
                  case (r_op)
                     c_OP_AND, c_OP_ADD, c_OP_LDA, c_OP_ISZ: begin
                        x_sel    = c_X_M;
                        dr_ld    = 1'b1;
                        w_sc_nxt = c_T5;
                     end
                     c_OP_STA: begin
                        x_sel  = c_X_AC;
                        mem_wr = 1'b1;
                        w_clr  = 1'b1;
                     end
                     c_OP_BUN: begin
                        x_sel = c_X_AR;
                        pc_ld = 1'b1;
                        w_clr = 1'b1;
                     end
                     c_OP_BSA: begin
                        x_sel    = c_X_PC;
                        mem_wr   = 1'b1;
                        ar_inc   = 1'b1;
                        w_sc_nxt = c_T5;
                     end
                     default: w_clr = 1'b1;
                  endcase
               end
               c_T5: begin
                  case (r_op)
                     c_OP_AND: begin
                        alu_sel = 2'b01;
                        ac_ld   = 1'b1;
                        w_clr   = 1'b1;
                     end
                     c_OP_ADD: begin
                        alu_sel = 2'b10;
                        ac_ld   = 1'b1;
                        w_clr   = 1'b1;
                     end
                     c_OP_LDA: begin
                        alu_sel = 2'b11;
                        ac_ld   = 1'b1;
                        w_clr   = 1'b1;
                     end
                     c_OP_BSA: begin
                        x_sel = c_X_AR;
                        pc_ld = 1'b1;
                        w_clr = 1'b1;
                     end
                     c_OP_ISZ: begin
                        dr_inc   = 1'b1;
                        w_sc_nxt = c_T6;
                     end
                     default: w_clr = 1'b1;
                  endcase
               end
               c_T6: begin
                  if (r_op == c_OP_ISZ) begin
                     // dr_zero already reflects the DR incremented at T5
                     x_sel  = c_X_DR;
                     mem_wr = 1'b1;
                     pc_inc = dr_zero;
                  end
                  w_clr = 1'b1;
               end
               default: w_clr = 1'b1;
            endcase
         end

         if (w_clr) begin
            w_sc_nxt     = c_T0;
            w_active_nxt = 1'b0;
         end
      end
   end

   // Sequence counter, activity flag and latched opcode/indirect bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sc     <= c_T0;
         r_op     <= 3'd0;
         r_iq     <= 1'b0;
         r_active <= 1'b0;
      end else begin
         r_sc     <= w_sc_nxt;
         r_active <= w_active_nxt;
         if (w_latch) begin
            r_op <= ir_op;
            r_iq <= ir_i;
         end
      end
   end

   // TR load is reserved for interrupt support
   assign tr_ld = 1'b0;
   assign i_q   = r_iq;
   assign t_cnt = r_sc;

endmodule
`default_nettype wire

// File: tb/tb_bus_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_control_sequencer
// Purpose  : Self-checking bench: directed instruction sequences with literal
//            expectations plus randomized run/opcode/reset traffic checked
//            every cycle against an instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_control_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       run;
   logic [2:0] ir_op;
   logic       ir_i;
   logic       dr_zero;
   logic [6:0] x_sel;
   logic       ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, dr_inc;
   logic       ac_ld, ir_ld, tr_ld, mem_wr, rr_exec, i_q;
   logic [1:0] alu_sel;
   logic [2:0] t_cnt;

   bus_control_sequencer #(.SC_W(3)) dut (
      .clk(clk), .rst(rst), .run(run), .ir_op(ir_op), .ir_i(ir_i),
      .dr_zero(dr_zero), .x_sel(x_sel), .ar_ld(ar_ld), .ar_inc(ar_inc),
      .pc_ld(pc_ld), .pc_inc(pc_inc), .dr_ld(dr_ld), .dr_inc(dr_inc),
      .ac_ld(ac_ld), .ir_ld(ir_ld), .tr_ld(tr_ld), .mem_wr(mem_wr),
      .alu_sel(alu_sel), .rr_exec(rr_exec), .i_q(i_q), .t_cnt(t_cnt)
   );

   always #5 clk = ~clk;

   // Flag vector bit positions
   localparam int F_ARLD = 10, F_ARINC = 9, F_PCLD = 8, F_PCINC = 7;
   localparam int F_DRLD = 6, F_DRINC = 5, F_ACLD = 4, F_IRLD = 3;
   localparam int F_TRLD = 2, F_MEMWR = 1, F_RR = 0;

   localparam logic [6:0] XM = 7'b1000000, XIR = 7'b0010000, XAC = 7'b0001000;
   localparam logic [6:0] XDR = 7'b0000100, XPC = 7'b0000010, XAR = 7'b0000001;

   logic [10:0] fl_now;
   assign fl_now = {ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, dr_inc, ac_ld,
                    ir_ld, tr_ld, mem_wr, rr_exec};

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model: one entry per expected cycle ----------
   typedef struct {
      logic [6:0]  x;
      logic [10:0] f;
      logic [1:0]  alu;
      logic        dz;   // pc_inc follows dr_zero in this cycle
      logic        lat;  // opcode/indirect captured in this cycle
      logic [2:0]  t;
   } ent_t;

   ent_t q[$];
   logic m_iq = 1'b0;

   function automatic logic [10:0] fb(input int pos);
      logic [10:0] v;
      v = '0;
      v[pos] = 1'b1;
      return v;
   endfunction

   task automatic push(input logic [2:0] t, input logic [6:0] x,
                       input logic [10:0] f, input logic [1:0] alu,
                       input logic dz, input logic lat);
      ent_t e;
      e.t = t; e.x = x; e.f = f; e.alu = alu; e.dz = dz; e.lat = lat;
      q.push_back(e);
   endtask

   // Remaining cycles of an instruction once its opcode is known
   task automatic push_exec(input logic [2:0] op, input logic ind);
      if (op == 3'd7) begin
         push(3'd3, 7'b0, fb(F_RR), 2'b00, 1'b0, 1'b0);
      end else begin
         if (ind) push(3'd3, XM, fb(F_ARLD), 2'b00, 1'b0, 1'b0);
         else     push(3'd3, 7'b0, 11'b0, 2'b00, 1'b0, 1'b0);
         case (op)
            3'd0, 3'd1, 3'd2: begin
               push(3'd4, XM, fb(F_DRLD), 2'b00, 1'b0, 1'b0);
               push(3'd5, 7'b0, fb(F_ACLD), 2'(op + 3'd1), 1'b0, 1'b0);
            end
            3'd3: push(3'd4, XAC, fb(F_MEMWR), 2'b00, 1'b0, 1'b0);
            3'd4: push(3'd4, XAR, fb(F_PCLD), 2'b00, 1'b0, 1'b0);
            3'd5: begin
               push(3'd4, XPC, fb(F_MEMWR) | fb(F_ARINC), 2'b00, 1'b0, 1'b0);
               push(3'd5, XAR, fb(F_PCLD), 2'b00, 1'b0, 1'b0);
            end
            default: begin
               push(3'd4, XM, fb(F_DRLD), 2'b00, 1'b0, 1'b0);
               push(3'd5, 7'b0, fb(F_DRINC), 2'b00, 1'b0, 1'b0);
               push(3'd6, XDR, fb(F_MEMWR), 2'b00, 1'b1, 1'b0);
            end
         endcase
      end
   endtask

   logic [6:0]  ex;
   logic [10:0] ef;
   logic [1:0]  ea;
   logic [2:0]  et;
   logic        iq_nxt;
   ent_t        ce;

   // Compare DUT outputs with the model every cycle, then advance the model
   always @(negedge clk) begin
      ex = 7'b0; ef = 11'b0; ea = 2'b00; et = 3'd0; iq_nxt = m_iq;
      if (rst) begin
         q.delete();
         m_iq   = 1'b0;
         iq_nxt = 1'b0;
      end else if (q.size() == 0) begin
         if (run) begin
            ex = XPC;
            ef = fb(F_ARLD);
            push(3'd1, XM, fb(F_IRLD) | fb(F_PCINC), 2'b00, 1'b0, 1'b0);
            push(3'd2, XIR, fb(F_ARLD), 2'b00, 1'b0, 1'b1);
         end
      end else begin
         ce = q.pop_front();
         ex = ce.x; ef = ce.f; ea = ce.alu; et = ce.t;
         if (ce.dz && dr_zero) ef[F_PCINC] = 1'b1;
         if (ce.lat) begin
            push_exec(ir_op, ir_i);
            iq_nxt = ir_i;
         end
      end
      chk("cycle{x,fl,alu,t,iq}", 32'({x_sel, fl_now, alu_sel, t_cnt, i_q}),
          32'({ex, ef, ea, et, m_iq}));
      m_iq = iq_nxt;
   end

   // ---------------- directed stimulus helpers ------------------------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   logic [6:0]  xs[7];
   logic [10:0] fl[7];
   logic [1:0]  al[7];
   logic [2:0]  tc[7];
   logic        iqs[7];

   task automatic rec(input int c);
      xs[c] = x_sel; fl[c] = fl_now; al[c] = alu_sel; tc[c] = t_cnt; iqs[c] = i_q;
   endtask

   // Run one instruction of n cycles, recording each cycle's outputs
   task automatic run_instr(input logic [2:0] op, input logic ind,
                            input logic dz, input int n);
      tick();
      run = 1'b1; ir_op = op; ir_i = ind; dr_zero = dz;
      sample(); rec(0);
      for (int c = 1; c < n; c++) begin
         tick();
         sample(); rec(c);
      end
   endtask

   int rr_cnt;

   initial begin
      rst = 1'b1; run = 1'b0; ir_op = 3'd0; ir_i = 1'b0; dr_zero = 1'b0;
      tick(); tick();
      rst = 1'b0;

      // Stalled at T0
      for (int k = 0; k < 5; k++) begin
         tick(); sample();
         chk("stall t_cnt", 32'(t_cnt), 32'd0);
         chk("stall x_sel/flags", 32'({x_sel, fl_now, alu_sel}), 32'd0);
      end

      // ADD direct
      run_instr(3'd1, 1'b0, 1'b0, 6);
      chk("ADD T0 x_sel", 32'(xs[0]), 32'(7'b0000010));
      chk("ADD T0 ar_ld", 32'(fl[0][F_ARLD]), 32'd1);
      chk("ADD x seq", 32'({xs[1], xs[2], xs[3], xs[4]}),
          32'({7'b1000000, 7'b0010000, 7'b0000000, 7'b1000000}));
      chk("ADD T5 x_sel", 32'(xs[5]), 32'd0);
      chk("ADD T5 alu/ac_ld", 32'({al[5], fl[5][F_ACLD]}), 32'({2'b10, 1'b1}));
      chk("ADD T5 t_cnt", 32'(tc[5]), 32'd5);

      // LDA indirect
      run_instr(3'd2, 1'b1, 1'b0, 6);
      chk("ADD->LDA restart t_cnt", 32'(tc[0]), 32'd0);
      chk("LDA T3 x/ar_ld/iq", 32'({xs[3], fl[3][F_ARLD], iqs[3]}),
          32'({7'b1000000, 1'b1, 1'b1}));
      chk("LDA T5 alu", 32'(al[5]), 32'b11);

      // ISZ with dr_zero=1, then dr_zero=0
      run_instr(3'd6, 1'b0, 1'b1, 7);
      chk("LDA length", 32'(tc[0]), 32'd0);
      chk("ISZ dz1 T6", 32'({tc[6], xs[6], fl[6][F_MEMWR], fl[6][F_PCINC]}),
          32'({3'd6, 7'b0000100, 1'b1, 1'b1}));
      run_instr(3'd6, 1'b0, 1'b0, 7);
      chk("ISZ length", 32'(tc[0]), 32'd0);
      chk("ISZ dz0 T6 pc_inc", 32'({xs[6], fl[6][F_PCINC]}), 32'({7'b0000100, 1'b0}));

      // BSA then register-reference
      run_instr(3'd5, 1'b0, 1'b0, 6);
      chk("BSA T4", 32'({xs[4], fl[4][F_MEMWR], fl[4][F_ARINC]}),
          32'({7'b0000010, 1'b1, 1'b1}));
      chk("BSA T5", 32'({xs[5], fl[5][F_PCLD]}), 32'({7'b0000001, 1'b1}));
      run_instr(3'd7, 1'b0, 1'b0, 4);
      rr_cnt = 0;
      for (int c = 0; c < 4; c++) rr_cnt += int'(fl[c][F_RR]);
      chk("RR T3 rr_exec", 32'(fl[3][F_RR]), 32'd1);
      chk("RR rr_exec count", 32'(rr_cnt), 32'd1);
      tick(); run = 1'b0; sample();
      chk("RR after t_cnt/rr", 32'({t_cnt, rr_exec}), 32'd0);

      // Reset pulsed at T5 of AND
      run_instr(3'd0, 1'b0, 1'b0, 5);
      chk("AND T4 t_cnt", 32'(tc[4]), 32'd4);
      run = 1'b0;
      tick(); rst = 1'b1;
      sample();
      chk("rst@T5 ac_ld/t_cnt/x", 32'({ac_ld, t_cnt, x_sel}), 32'd0);
      tick(); rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         sample();
         chk("post-rst quiet", 32'({ac_ld, t_cnt, x_sel, fl_now}), 32'd0);
         tick();
      end

      // run dropped at T2 of STA
      run = 1'b1; ir_op = 3'd3; ir_i = 1'b0;
      sample(); rec(0);
      tick(); sample(); rec(1);
      tick(); run = 1'b0;
      for (int c = 2; c < 5; c++) begin
         sample(); rec(c);
         tick();
      end
      chk("STA T4 x/mem_wr", 32'({tc[4], xs[4], fl[4][F_MEMWR]}),
          32'({3'd4, 7'b0001000, 1'b1}));
      for (int k = 0; k < 2; k++) begin
         sample();
         chk("STA stall", 32'({t_cnt, x_sel, fl_now, alu_sel}), 32'd0);
         tick();
      end

      // Randomized traffic; the compare process checks every cycle
      for (int k = 0; k < 3000; k++) begin
         run     = ($urandom_range(0, 9) < 8);
         ir_op   = 3'($urandom_range(0, 7));
         ir_i    = 1'($urandom_range(0, 1));
         dr_zero = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 199) == 0) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
         end
         tick();
      end

      sample();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bus_control_sequencer.md
Name: bus_control_sequencer

Overview:
- Timing and control sequencer for the basic computer. Runs the sequence counter (SC) through the fetch, decode, indirect and execute phases.
- Generates the 7-bit one-hot bus source select that feeds the common-bus select encoder, plus the register load/increment, memory-write and ALU-select strobes.
- Sits directly upstream of the bus select encoder, and beside the register file and ALU.

Parameters:
- SC_W, 3, sequence counter width; covers T0..T6.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  enable; sampled only at T0.
- ir_op  in  3  IR[14:12] opcode from the IR register.
- ir_i  in  1  IR[15] indirect bit.
- dr_zero  in  1  high when the DR register value is 0.
- x_sel  out  7  bus source select; at most one bit set. Bit mapping: [6]=M, [5]=TR, [4]=IR, [3]=AC, [2]=DR, [1]=PC, [0]=AR.
- ar_ld, ar_inc  out  1  AR load from bus / AR increment.
- pc_ld, pc_inc  out  1  PC load from bus / PC increment.
- dr_ld, dr_inc  out  1  DR load from bus / DR increment.
- ac_ld  out  1  AC load from ALU.
- ir_ld  out  1  IR load from bus.
- tr_ld  out  1  TR load; tied 0 in this revision, reserved for interrupt support.
- mem_wr  out  1  memory write of bus data at address AR.
- alu_sel  out  2  ALU function: 00 = none, 01 = AND, 10 = ADD, 11 = pass DR.
- rr_exec  out  1  one-cycle strobe to the register-reference/IO decoder.
- i_q  out  1  latched indirect bit.
- t_cnt  out  SC_W  current SC value.

Behaviour:
- State registers:
  - SC (SC_W bits).
  - op_q (3 bits) and i_q, both latched at T2 from ir_op and ir_i.
  - active flag: set when leaving T0 with run=1.
- Reset: asynchronous. SC=0, op_q=0, i_q=0, active=0.
- Output timing: all strobes and x_sel are combinational decodes of (SC, op_q, i_q, active, run). They are valid in the cycle of their Tn and take effect at the next rising edge.
- Outputs while stalled:
  - At T0 with run=0, SC holds at 0 and every output is 0 (x_sel=0000000).
  - x_sel=0 in any cycle with no bus transfer.
- Stopping: run is sampled only at T0. Dropping run mid-instruction does not abort the instruction; the sequencer completes it and stalls at the next T0.
- Fetch/decode/indirect:
  - T0 (run=1): x_sel=PC, ar_ld.
  - T1: x_sel=M, ir_ld, pc_inc.
  - T2: x_sel=IR, ar_ld; latch op_q<=ir_op and i_q<=ir_i.
  - T3, op_q=7: rr_exec, then SC<=0.
  - T3, op_q!=7 and i_q=1: x_sel=M, ar_ld.
  - T3, op_q!=7 and i_q=0: no strobes.
  - T3 with op_q!=7 always continues to T4.
- Execute ("clr" means SC<=0 at the next edge; otherwise SC<=SC+1):
  - AND (0): T4 x_sel=M, dr_ld; T5 alu_sel=01, ac_ld, clr.
  - ADD (1): T4 x_sel=M, dr_ld; T5 alu_sel=10, ac_ld, clr.
  - LDA (2): T4 x_sel=M, dr_ld; T5 alu_sel=11, ac_ld, clr.
  - STA (3): T4 x_sel=AC, mem_wr, clr.
  - BUN (4): T4 x_sel=AR, pc_ld, clr.
  - BSA (5): T4 x_sel=PC, mem_wr, ar_inc; T5 x_sel=AR, pc_ld, clr.
  - ISZ (6): T4 x_sel=M, dr_ld; T5 dr_inc; T6 x_sel=DR, mem_wr, pc_inc iff dr_zero, clr. dr_zero at T6 reflects the incremented DR.
- Instruction lengths in cycles, from T0 to return to T0:
  - register-ref 4
  - STA and BUN 5
  - AND, ADD, LDA and BSA 6
  - ISZ 7
  - indirect adds no cycles, because T3 is always spent.
- Illegal SC state: any SC value not reached by the current opcode forces clr with all strobes 0.
- Mid-operation reset: rst asserted in any Tn immediately zeroes every output and returns SC to 0, with no partial strobe after release.
- Wrap-around: SC never exceeds 6 and never wraps by counting.

Test Plan:
- Reset, then run=0 for 5 cycles -> t_cnt=0 and x_sel=0000000 with all strobes 0 each cycle. Then run=1 -> T0 shows x_sel=0000010 and ar_ld=1.
- ADD direct (ir_op=1, ir_i=0) -> x_sel sequence across T0..T5 is 0000010, 1000000, 0010000, 0000000, 1000000, 0000000. alu_sel=10 and ac_ld at T5, then t_cnt=0.
- LDA indirect (ir_op=2, ir_i=1) -> T3 x_sel=1000000 with ar_ld=1, i_q=1; T5 alu_sel=11. Total 6 cycles.
- ISZ with dr_zero=1 at T6 -> T6 x_sel=0000100, mem_wr=1, pc_inc=1; 7 cycles. Repeat with dr_zero=0 -> pc_inc=0.
- BSA then register-ref (ir_op=7) -> BSA T4 x_sel=0000010 with mem_wr and ar_inc; T5 x_sel=0000001 with pc_ld. Register-ref T3 rr_exec=1 for exactly one cycle, then t_cnt=0.
- rst pulsed at T5 of AND; separately, run dropped at T2 of STA -> reset case: ac_ld never asserts and t_cnt=0 asynchronously. Run case: STA completes (T4 mem_wr=1), then the sequencer stalls at T0 with outputs 0.
